traffic_light_ctrl: RTL and testbench
=====================================

Name: traffic_light_ctrl

Overview:
Parametrised two-road intersection controller. It is the successor of the fixed 4-phase NS/EW light. Adds programmable phase durations, all-red clearance intervals, a latched pedestrian-walk phase and a flashing-yellow maintenance mode. Timing is advanced by a 1-cycle-per-second tick pulse from the shared prescaler. Outputs drive lamp drivers directly.

Parameters:
G_TIME, 5, green duration in ticks (1..2^CW)
Y_TIME, 2, yellow duration in ticks (1..2^CW)
R_CLR, 1, all-red clearance duration in ticks (1..2^CW)
WALK_TIME, 4, pedestrian walk duration in ticks (1..2^CW)
CW, 4, phase counter width; every duration minus 1 must fit in CW bits

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  asynchronous active-high reset
tick  in  1  1-cycle pulse, one per second
ped_req  in  1  pedestrian button, a 1-cycle pulse or a level; sampled every clk
flash_en  in  1  maintenance mode request, level
ns_g, ns_y, ns_r  out  1 each  NS lamps
ew_g, ew_y, ew_r  out  1 each  EW lamps
walk  out  1  pedestrian WALK lamp
ped_pend  out  1  pedestrian request latched and not yet served

Behaviour:
- Reset is asynchronous, active-high, on clk and rst. It is the only reset in the block.
- Reset values: state=NS_G, cnt=G_TIME-1, ped_pend=0, flash_ph=1. Outputs during reset: ns_g=1, ew_r=1, all other outputs 0.
- States: NS_G, NS_Y, CLR1, EW_G, EW_Y, CLR2, WALK, FLASH.
- Phase timing (normal states):
  - On entry, cnt loads D-1, where D is that phase's duration.
  - On a cycle with tick=1: if cnt!=0, cnt decrements; if cnt==0, the block transitions to the next state.
  - A phase therefore lasts exactly D ticks after entry.
  - With tick=0, state and cnt hold.
- Normal sequence:
  - NS_G, then NS_Y, then CLR1, then EW_G, then EW_Y, then CLR2.
  - CLR2 exits to WALK if ped_pend=1, otherwise to NS_G.
  - WALK exits to NS_G.
- Moore outputs (exactly one lamp per road is lit):
  - NS_G: ns_g, ew_r
  - NS_Y: ns_y, ew_r
  - EW_G: ns_r, ew_g
  - EW_Y: ns_r, ew_y
  - CLR1/CLR2: ns_r, ew_r
  - WALK: ns_r, ew_r, walk
  - FLASH: ns_y=ew_y=flash_ph; all g, r and walk outputs are 0.
- ped_pend:
  - Set when ped_req=1 and state!=WALK; set wins if ped_req arrives on the same cycle as a transition.
  - Cleared on every cycle in WALK, so requests during WALK are ignored.
  - Held through FLASH.
  - A level-held ped_req behaves the same as a single pulse.
- Flash mode:
  - flash_en=1 in any state forces FLASH on the next clk edge, regardless of tick and mid-phase.
  - Entry sets flash_ph=1.
  - In FLASH, flash_ph toggles on each tick; cnt is don't-care.
  - When flash_en=0 while in FLASH, the next state is CLR2 with cnt=R_CLR-1. Normal ped_pend routing then applies at CLR2 exit.
  - flash_en has priority over tick-driven transitions on the same cycle.
- Counter arithmetic is unsigned CW-bit with no wrap; cnt never decrements below 0.
- Safety invariant: ns_g|ns_y and ew_g|ew_y are never both 1 outside FLASH. walk=1 only when ns_r=ew_r=1.
- Illegal state encoding recovers to NS_G with cnt=G_TIME-1 on the next edge.

Test Plan:
- Reset, then tick every 4 clks with defaults -> NS_G 5 ticks, NS_Y 2, CLR1 1, EW_G 5, EW_Y 2, CLR2 1, then NS_G again (16-tick cycle); walk stays 0.
- 1-cycle ped_req during EW_G -> ped_pend=1 next clk; after CLR2 expires, WALK for 4 ticks with walk=1 and ped_pend=0; then NS_G.
- ped_req pulses during WALK -> ped_pend stays 0; next cycle has no WALK.
- flash_en=1 mid NS_G (cnt=2) -> FLASH next clk with ns_y=ew_y=1, toggling per tick (1,0,1). Drop flash_en -> CLR2 for 1 tick, then NS_G (or WALK if ped_req was latched during FLASH).
- Assert rst asynchronously mid EW_Y (between edges) -> outputs go to ns_g=1, ew_r=1 immediately; after release, NS_G lasts the full 5 ticks.
- Override G_TIME=1, Y_TIME=1, R_CLR=2, CW=2 -> each phase lasts its parameter's tick count; the safety invariant is checked every cycle by assertion.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// Lamp-driver and control signal bundle for the intersection controller.
interface traffic_light_ctrl_if;
    logic tick;
    logic ped_req;
    logic flash_en;
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    logic walk;
    logic ped_pend;

    // Driver side: supplies tick, button and maintenance request, observes lamps
    modport master (
        output tick, ped_req, flash_en,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend
    );

    // Controller side
    modport slave (
        input  tick, ped_req, flash_en,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: programmable phase lengths, all-red
// clearance, latched pedestrian walk phase and flashing-yellow maintenance mode.
module traffic_light_ctrl #(
    parameter int unsigned G_TIME    = 5,
    parameter int unsigned Y_TIME    = 2,
    parameter int unsigned R_CLR     = 1,
    parameter int unsigned WALK_TIME = 4,
    parameter int unsigned CW        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        StNsG   = 3'd0,
        StNsY   = 3'd1,
        StClr1  = 3'd2,
        StEwG   = 3'd3,
        StEwY   = 3'd4,
        StClr2  = 3'd5,
        StWalk  = 3'd6,
        StFlash = 3'd7
    } state_e;

    localparam logic [CW-1:0] GLoad = CW'(G_TIME - 1);
    localparam logic [CW-1:0] YLoad = CW'(Y_TIME - 1);
    localparam logic [CW-1:0] RLoad = CW'(R_CLR - 1);
    localparam logic [CW-1:0] WLoad = CW'(WALK_TIME - 1);

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    localparam logic [6:0] LampNsG  = 7'b1000010;
    localparam logic [6:0] LampNsY  = 7'b0100010;
    localparam logic [6:0] LampEwG  = 7'b0011000;
    localparam logic [6:0] LampEwY  = 7'b0010100;
    localparam logic [6:0] LampClr  = 7'b0010010;
    localparam logic [6:0] LampWalk = 7'b0010011;

    state_e        state_q, state_d, succ_state;
    logic [CW-1:0] cnt_q, cnt_d, succ_load;
    logic          ped_pend_q, ped_pend_d;
    logic          flash_ph_q, flash_ph_d;
    logic [6:0]    lamps_q, lamps_d;

    // Successor phase and its counter load when the current phase expires
    always_comb begin
        succ_state = StNsG;
        succ_load  = GLoad;
        case (state_q)
            StNsG:  begin succ_state = StNsY;  succ_load = YLoad; end
            StNsY:  begin succ_state = StClr1; succ_load = RLoad; end
            StClr1: begin succ_state = StEwG;  succ_load = GLoad; end
            StEwG:  begin succ_state = StEwY;  succ_load = YLoad; end
            StEwY:  begin succ_state = StClr2; succ_load = RLoad; end
            StClr2: begin
                if (ped_pend_q) begin
                    succ_state = StWalk;
                    succ_load  = WLoad;
                end
            end
            default: begin succ_state = StNsG; succ_load = GLoad; end
        endcase
    end

    // Next state: flash request overrides everything, else tick-driven phase timing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flash_ph_d = flash_ph_q;
        ped_pend_d = ped_pend_q;

        // Requests made while walking are dropped; a new request wins over a transition
        if (state_q == StWalk) begin
            ped_pend_d = 1'b0;
        end else if (bus.ped_req) begin
            ped_pend_d = 1'b1;
        end

        if (bus.flash_en) begin
            state_d    = StFlash;
            flash_ph_d = (state_q != StFlash) ? 1'b1 : (flash_ph_q ^ bus.tick);
        end else if (state_q == StFlash) begin
            // Leave maintenance through an all-red clearance before traffic resumes
            state_d = StClr2;
            cnt_d   = RLoad;
        end else if (bus.tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d = succ_state;
                cnt_d   = succ_load;
            end
        end
    end

    // Lamp decode from the next state so the lamp flops track the state flops
    always_comb begin
        case (state_d)
            StNsY:   lamps_d = LampNsY;
            StClr1:  lamps_d = LampClr;
            StEwG:   lamps_d = LampEwG;
            StEwY:   lamps_d = LampEwY;
            StClr2:  lamps_d = LampClr;
            StWalk:  lamps_d = LampWalk;
            StFlash: lamps_d = {1'b0, flash_ph_d, 2'b00, flash_ph_d, 2'b00};
            default: lamps_d = LampNsG;
        endcase
    end

    // State, counter, pedestrian latch and registered lamp outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StNsG;
            cnt_q      <= GLoad;
            ped_pend_q <= 1'b0;
            flash_ph_q <= 1'b1;
            lamps_q    <= LampNsG;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            flash_ph_q <= flash_ph_d;
            lamps_q    <= lamps_d;
        end
    end

    assign bus.ns_g     = lamps_q[6];
    assign bus.ns_y     = lamps_q[5];
    assign bus.ns_r     = lamps_q[4];
    assign bus.ew_g     = lamps_q[3];
    assign bus.ew_y     = lamps_q[2];
    assign bus.ew_r     = lamps_q[1];
    assign bus.walk     = lamps_q[0];
    assign bus.ped_pend = ped_pend_q;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: default instance plus a short-timing instance.
module tb_traffic_light_ctrl;
    // Observed vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pend}
    localparam logic [7:0] NSG = 8'b10000100;
    localparam logic [7:0] NSY = 8'b01000100;
    localparam logic [7:0] CLR = 8'b00100100;
    localparam logic [7:0] EWG = 8'b00110000;
    localparam logic [7:0] EWY = 8'b00101000;
    localparam logic [7:0] WLK = 8'b00100110;
    localparam logic [7:0] FL1 = 8'b01001000;
    localparam logic [7:0] FL0 = 8'b00000000;
    localparam logic [7:0] PND = 8'b00000001;

    // Lamps after each tick of one default cycle, counted from a fresh NS_G
    logic [7:0] seq1 [0:15] = '{NSG, NSG, NSG, NSG, NSY, NSY, CLR, EWG,
                                EWG, EWG, EWG, EWG, EWY, EWY, CLR, NSG};
    // G=1, Y=1, R_CLR=2 instance, counted from reset
    logic [7:0] seq2 [0:7]  = '{NSY, CLR, CLR, EWG, EWY, CLR, CLR, NSG};

    logic clk;
    logic rst;
    logic rst2;
    logic flash_lvl;

    int n_cmp;
    int n_err;

    logic [7:0] q1_exp [$];
    string      q1_name [$];
    logic [7:0] q2_exp [$];
    string      q2_name [$];

    logic [7:0] obs1, obs2;
    logic [7:0] mon_e;
    string      mon_n;

    traffic_light_ctrl_if tl1 ();
    traffic_light_ctrl_if tl2 ();

    traffic_light_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (tl1)
    );

    traffic_light_ctrl #(
        .G_TIME    (1),
        .Y_TIME    (1),
        .R_CLR     (2),
        .WALK_TIME (4),
        .CW        (2)
    ) u_dut_short (
        .clk (clk),
        .rst (rst2),
        .bus (tl2)
    );

    assign tl2.tick     = tl1.tick;
    assign tl2.ped_req  = tl1.ped_req;
    assign tl2.flash_en = tl1.flash_en;

    assign obs1 = {tl1.ns_g, tl1.ns_y, tl1.ns_r, tl1.ew_g, tl1.ew_y, tl1.ew_r,
                   tl1.walk, tl1.ped_pend};
    assign obs2 = {tl2.ns_g, tl2.ns_y, tl2.ns_r, tl2.ew_g, tl2.ew_y, tl2.ew_r,
                   tl2.walk, tl2.ped_pend};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One lamp per road outside flash; in flash no green/red/walk; walk only with all-red
    task automatic chk_safe(input logic [7:0] v, input string n);
        logic flash;
        logic ok;
        flash = !v[7] && !v[5] && !v[4] && !v[2];
        if (flash) ok = !v[1];
        else ok = $onehot({v[7], v[6], v[5]}) && $onehot({v[4], v[3], v[2]}) &&
                  (!v[1] || (v[5] && v[2]));
        n_cmp++;
        assert (ok) else begin
            n_err++;
            $display("FAIL %s safety: lamps %b violate invariant", n, v);
        end
    endtask

    // Monitor: lamps are presented every cycle; pop whatever the driver queued
    initial begin
        forever begin
            @(negedge clk);
            while (q1_exp.size() > 0) begin
                mon_e = q1_exp.pop_front();
                mon_n = q1_name.pop_front();
                n_cmp++;
                if (obs1 !== mon_e) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b", mon_n, obs1, mon_e);
                end
            end
            while (q2_exp.size() > 0) begin
                mon_e = q2_exp.pop_front();
                mon_n = q2_name.pop_front();
                n_cmp++;
                if (obs2 !== mon_e) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b", mon_n, obs2, mon_e);
                end
            end
            chk_safe(obs1, "dut");
            chk_safe(obs2, "dut_short");
        end
    end

    task automatic expect1(input string n, input logic [7:0] v);
        q1_exp.push_back(v);
        q1_name.push_back(n);
    endtask

    task automatic expect2(input string n, input logic [7:0] v);
        q2_exp.push_back(v);
        q2_name.push_back(n);
    endtask

    // One clock with the given tick/button; flash_en follows flash_lvl
    task automatic cyc(input logic t, input logic p);
        tl1.tick     = t;
        tl1.ped_req  = p;
        tl1.flash_en = flash_lvl;
        @(posedge clk);
        #1;
        tl1.tick    = 1'b0;
        tl1.ped_req = 1'b0;
    endtask

    // One second: tick on the first of four clocks
    task automatic do_tick();
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    task automatic run_cycle(input string tag);
        for (int i = 0; i < 16; i++) begin
            do_tick();
            expect1($sformatf("%s t%0d", tag, i + 1), seq1[i]);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        rst2         = 1'b1;
        flash_lvl    = 1'b0;
        tl1.tick     = 1'b0;
        tl1.ped_req  = 1'b0;
        tl1.flash_en = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        expect1("reset", NSG);
        expect2("short reset", NSG);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain 16-tick cycle
        run_cycle("base");

        // Pedestrian request during EW_G
        for (int i = 0; i < 8; i++) do_tick();
        expect1("reach ew_g", EWG);
        cyc(1'b0, 1'b1);
        expect1("ped latched", EWG | PND);
        for (int i = 8; i < 15; i++) begin
            do_tick();
            expect1($sformatf("ped pend t%0d", i + 1), seq1[i] | PND);
        end
        do_tick();
        expect1("walk entry", WLK);
        cyc(1'b0, 1'b1);
        expect1("ped in walk ignored", WLK);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            expect1($sformatf("walk t%0d", i + 2), WLK);
        end
        do_tick();
        expect1("walk exit", NSG);
        run_cycle("after walk");

        // Flash entry mid NS_G, on a tick cycle
        do_tick();
        do_tick();
        expect1("ns_g cnt2", NSG);
        flash_lvl = 1'b1;
        cyc(1'b1, 1'b0);
        expect1("flash entry", FL1);
        do_tick();
        expect1("flash t1", FL0);
        do_tick();
        expect1("flash t2", FL1);
        cyc(1'b0, 1'b1);
        expect1("ped in flash", FL1 | PND);
        flash_lvl = 1'b0;
        cyc(1'b0, 1'b0);
        expect1("flash exit clr2", CLR | PND);
        do_tick();
        expect1("clr2 to walk", WLK);
        for (int i = 0; i < 3; i++) do_tick();
        expect1("walk held", WLK);
        do_tick();
        expect1("walk to ns_g", NSG);

        // Asynchronous reset mid EW_Y
        for (int i = 0; i < 13; i++) do_tick();
        expect1("reach ew_y", EWY);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect1("async reset", NSG);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycle("post reset");

        // Short-timing instance
        rst2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_tick();
            expect2($sformatf("short t%0d", i + 1), seq2[i]);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q1_exp.size() + q2_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0",
                     q1_exp.size() + q2_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
